// File: rtl/wpm_pkg.sv
// Shared constants and types for the WPM BCD path (encoder and display driver).
package wpm_pkg;

  localparam int NUM_DIGITS         = 5;
  localparam int WPM_MAX_HUNDREDTHS = 99999;
  localparam int BCD_W              = 4 * NUM_DIGITS;

  // Digit positions inside the packed 20-bit BCD accumulator, LSB first.
  localparam int DIG_HUNDREDTHS = 0;
  localparam int DIG_TENTHS     = 1;
  localparam int DIG_ONES       = 2;
  localparam int DIG_TENS       = 3;
  localparam int DIG_HUNDREDS   = 4;

  // Integer part is {hundreds, tens, ones}; decimal part is {tenths, hundredths}.
  localparam int DEC_W   = 4 * DIG_ONES;
  localparam int INT_W   = BCD_W - DEC_W;
  localparam int INT_LSB = DEC_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Extract one BCD digit by index from a packed accumulator.
  function automatic logic [3:0] digit_of(input logic [BCD_W-1:0] bcd, input int idx);
    return bcd[4*idx +: 4];
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  logic w_ge5;

  assign w_ge5   = (i_digit >= 4'd5);
  assign o_digit = w_ge5 ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/wpm_bcd_encoder.sv
// Iterative binary-to-BCD converter for the WPM display (value in hundredths).
// IN_W shift cycles per conversion; results and overflow only move with done.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one add-3/shift iteration per cycle, IN_W iterations
//   DONE  | done pulse cycle with fresh outputs; back to IDLE next
module wpm_bcd_encoder
  import wpm_pkg::*;
#(
  parameter int IN_W = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] wpm_hundredths,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [11:0]     wpm_integer,
  output logic [7:0]      wpm_decimal
);

  localparam int                CNT_W    = $clog2(IN_W);
  localparam logic [IN_W-1:0]   SAT_VAL  = IN_W'(WPM_MAX_HUNDREDTHS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_W - 1);

  state_t             r_state;
  logic [IN_W-1:0]    r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [INT_W-1:0]   r_int;
  logic [DEC_W-1:0]   r_dec;

  logic               w_over;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_next;

  assign w_over = (wpm_hundredths > SAT_VAL);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Left shift of {adjusted bcd, bin}: the binary MSB enters the BCD LSB.
  assign w_bcd_next = {w_adj[BCD_W-2:0], r_bin[IN_W-1]};

  // Conversion FSM with registered outputs. The result registers load from the
  // final iteration's value on the edge entering DONE, so done and the new
  // result are visible together in the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_int      <= '0;
      r_dec      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin      <= w_over ? SAT_VAL : wpm_hundredths;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_over;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[IN_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_int   <= w_bcd_next[BCD_W-1:INT_LSB];
            r_dec   <= w_bcd_next[INT_LSB-1:0];
            r_ovf   <= r_ovf_pend;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign overflow    = r_ovf;
  assign wpm_integer = r_int;
  assign wpm_decimal = r_dec;

endmodule

// File: doc/wpm_bcd_encoder.md
# wpm_bcd_encoder

Sequential binary-to-BCD converter that produces the packed BCD words driving the seven-segment WPM display. It takes a binary words-per-minute value in hundredths and converts it with an iterative shift-and-add-3 (double-dabble) engine. It outputs three integer digits and two decimal digits. It sits between the WPM calculation logic and the display driver, and its outputs connect directly to the display's `wpm_integer` / `wpm_decimal` inputs.

## Interface

- `IN_W`, default 17: width of the binary input. Must be ≥ 17. The conversion takes `IN_W` shift cycles.
- `clk`  input  1  system clock. Single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `wpm_hundredths`  input  IN_W  binary WPM × 100 (13115 = 131.15 WPM). Sampled only when `start` is accepted.
- `start`  input  1  single-cycle conversion request.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when a new result is valid.
- `overflow`  output  1  set with `done` if the input exceeded 99999. Held until the next `done`.
- `wpm_integer`  output  12  BCD {hundreds, tens, ones}.
- `wpm_decimal`  output  8  BCD {tenths, hundredths}.

## Operation

- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `start`=1 is accepted. The block latches the saturated input `min(wpm_hundredths, 99999)` into the binary shift register.
  - It clears the 20-bit BCD accumulator and the cycle counter.
  - It latches the overflow compare result and moves to SHIFT.
- **SHIFT:** one iteration per cycle, in this order:
  - Add 3 to each of the 5 BCD digits that is ≥ 5.
  - Shift {bcd, bin} left by 1.
  - Increment the counter.
  - After iteration `IN_W` (counter reaches `IN_W`−1), move to DONE.
- **DONE:**
  - Register the accumulator into the outputs: `wpm_integer` = bcd[19:8], `wpm_decimal` = bcd[7:0].
  - Register `overflow` and pulse `done`.
  - Return to IDLE on the next cycle.
- **Output stability:** `wpm_integer`, `wpm_decimal` and `overflow` change only in the cycle that `done` is asserted. The display never sees partial results.
- **`start` outside IDLE** (SHIFT or DONE) is ignored. No queueing and no error flag.
- **Saturation:** inputs > 99999 convert as 99999 (999.99). `overflow`=1.
- **Digit width:** every digit is always in the range 0–9. Values ≥ 10 are a bug.
- **Reset:**
  - Any cycle with `reset`=1, including mid-SHIFT, aborts the conversion and forces IDLE.
  - All outputs go to 0: `busy`, `done`, `overflow`, `wpm_integer`=12'h000, `wpm_decimal`=8'h00.
  - `start` coincident with `reset` is ignored.

## Timing

- All outputs are registered. No combinational path from input to output.
- `start` is sampled at edge k (IDLE). `busy`=1 for cycles k+1 … k+`IN_W`+1, which are the SHIFT cycles plus the DONE cycle.
- With `IN_W`=17, `done`=1 and the new outputs are visible in cycle k+18.
- `busy` falls to 0 in the cycle after `done`. `start` is accepted again from that cycle, so the minimum start-to-start spacing is 19 cycles.
- Latency is fixed at `IN_W`+1 cycles from acceptance to `done`, independent of the value.

## Structure

- **Shared package (`wpm_pkg`):**
  - `NUM_DIGITS`=5
  - `WPM_MAX_HUNDREDTHS`=99999
  - `BCD_W`=20
  - state enum {IDLE, SHIFT, DONE}
  - digit-index constants for integer/decimal slicing (also used by the display driver)
- **Sub-module `bcd_digit_adjust`:** combinational, 4-bit in/out, adds 3 if the digit is ≥ 5. Instantiated `NUM_DIGITS` times in the SHIFT datapath.
- **Top:** FSM, counter (width `$clog2(IN_W)`), shift register, saturation compare, output registers.

## Test plan

1. Reset, then `start` with 13115 → `done` in cycle k+18. `wpm_integer`=12'h131, `wpm_decimal`=8'h15, `overflow`=0. `busy` is high for exactly 18 cycles.
2. Convert 0 and then 99999 back-to-back, each `start` issued the cycle after `busy` falls → 12'h000/8'h00, then 12'h999/8'h99. Neither sets `overflow`.
3. Input 150000 → 12'h999/8'h99 with `overflow`=1. A following input of 4207 gives 12'h042/8'h07 and clears `overflow`.
4. Convert 5000, then pulse `start` with 777 at cycles k+5 and k+18 → both pulses are ignored. A single `done` appears with 12'h050/8'h00, and no second conversion starts.
5. After a completed conversion of 12345, assert `reset` at cycle k+9 of a new conversion → all outputs read 0 the next cycle. There is no `done` pulse. A fresh `start` with 10001 yields 12'h100/8'h01.
6. Random inputs 0–131071 (1000 values) against a reference model → every digit ≤ 9, the result matches `min(x, 99999)`, and outputs change only when `done` is asserted.
